// File: rtl/mux_tree_pkg.sv
// rtl/mux_tree_pkg.sv - shared sizing helpers for the pipelined mux tree.
package mux_tree_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sel_width(input int n_ch);
    return clog2(n_ch);
  endfunction

  function automatic int tree_levels(input int n_ch);
    return clog2(n_ch);
  endfunction

  // Node count at a level: each level halves its inputs, rounding up.
  function automatic int nodes_at(input int n_ch, input int lvl);
    int n;
    n = n_ch;
    for (int i = 0; i <= lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int inputs_at(input int n_ch, input int lvl);
    return (lvl == 0) ? n_ch : nodes_at(n_ch, lvl - 1);
  endfunction

endpackage

// File: rtl/mux_tree_node.sv
// rtl/mux_tree_node.sv - one registered 2:1 cell of the mux tree.
module mux_tree_node #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         sel_i,
  input  logic [W-1:0] i0_i,
  input  logic [W-1:0] i1_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  assign q_d = sel_i ? i1_i : i0_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 mux tree with valid/ready and full stall.
// Optional out-of-range select flag: define MUX_TREE_SEL_ERR_EN.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel
`ifdef MUX_TREE_SEL_ERR_EN
  ,
  output logic              sel_err
`endif
);

  localparam int LEVELS = tree_levels(N_CH);
  localparam int MAXN   = N_CH;

  logic              adv;
  logic [W-1:0]      node_w [LEVELS+1][MAXN];
  logic [LEVELS-1:0] valid_q;
  logic [LEVELS-1:0] valid_d;
  logic [SEL_W-1:0]  sel_q [LEVELS];
  logic [SEL_W-1:0]  sel_d [LEVELS];

  assign out_valid = valid_q[LEVELS-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_sel   = sel_q[LEVELS-1];

  for (genvar c = 0; c < N_CH; c++) begin : g_leaf
    assign node_w[0][c] = in_data[c*W +: W];
  end

  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
    localparam int N_IN  = inputs_at(N_CH, lv);
    localparam int N_OUT = nodes_at(N_CH, lv);
    logic sel_bit;

    // Each level switches on its own select bit, taken from the beat's copy one level up.
    if (lv == 0) begin : g_s0
      assign sel_bit = in_sel[0];
    end else begin : g_sn
      assign sel_bit = sel_q[lv-1][lv];
    end

    for (genvar j = 0; j < MAXN; j++) begin : g_pos
      if (j < N_OUT) begin : g_node
        logic [W-1:0] i1;
        if (2*j + 1 < N_IN) begin : g_pair
          assign i1 = node_w[lv][2*j+1];
        end else begin : g_pad
          assign i1 = '0;
        end
        mux_tree_node #(.W(W)) u_node (
          .clk   (clk),
          .rst   (rst),
          .en_i  (adv),
          .sel_i (sel_bit),
          .i0_i  (node_w[lv][2*j]),
          .i1_i  (i1),
          .q_o   (node_w[lv+1][j])
        );
      end else begin : g_empty
        assign node_w[lv+1][j] = '0;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    sel_d   = sel_q;
    if (adv) begin
      valid_d[0] = in_valid;
      sel_d[0]   = in_sel;
      for (int lv = 1; lv < LEVELS; lv++) begin
        valid_d[lv] = valid_q[lv-1];
        sel_d[lv]   = sel_q[lv-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      sel_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

`ifdef MUX_TREE_SEL_ERR_EN
  localparam logic [SEL_W:0] N_CH_V = (SEL_W+1)'(N_CH);

  logic              in_oor;
  logic [LEVELS-1:0] err_q;
  logic [LEVELS-1:0] err_d;

  assign in_oor = ({1'b0, in_sel} >= N_CH_V);

  always_comb begin
    err_d = err_q;
    if (adv) begin
      err_d[0] = in_oor;
      for (int lv = 1; lv < LEVELS; lv++) begin
        err_d[lv] = err_q[lv-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign sel_err  = err_q[LEVELS-1];
  assign out_data = err_q[LEVELS-1] ? '0 : node_w[LEVELS][0];
`else
  assign out_data = node_w[LEVELS][0];
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - self-checking bench: directed table, corner sequences, random scoreboard.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8 channels x 8 bits
  logic        a_iv, a_ir, a_ov, a_ordy;
  logic [63:0] a_data;
  logic [2:0]  a_sel, a_osel;
  logic [7:0]  a_od;
  // 5 channels x 8 bits
  logic        b_iv, b_ir, b_ov, b_ordy;
  logic [39:0] b_data;
  logic [2:0]  b_sel, b_osel;
  logic [7:0]  b_od;
  // 2 channels x 16 bits
  logic        c_iv, c_ir, c_ov, c_ordy;
  logic [31:0] c_data;
  logic [0:0]  c_sel, c_osel;
  logic [15:0] c_od;
`ifdef MUX_TREE_SEL_ERR_EN
  logic a_err, b_err, c_err;
`endif

  mux_tree_pipe #(.N_CH(8), .W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_data),
    .in_sel(a_sel), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .out_sel(a_osel)
`ifdef MUX_TREE_SEL_ERR_EN
    , .sel_err(a_err)
`endif
  );

  mux_tree_pipe #(.N_CH(5), .W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_data),
    .in_sel(b_sel), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od), .out_sel(b_osel)
`ifdef MUX_TREE_SEL_ERR_EN
    , .sel_err(b_err)
`endif
  );

  mux_tree_pipe #(.N_CH(2), .W(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_data),
    .in_sel(c_sel), .out_valid(c_ov), .out_ready(c_ordy), .out_data(c_od), .out_sel(c_osel)
`ifdef MUX_TREE_SEL_ERR_EN
    , .sel_err(c_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [2:0] isel;
    logic       ordy;
    logic       eov;
    logic [7:0] eod;
    logic [2:0] esel;
    logic       eir;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic iv, input logic [2:0] isel, input logic ordy,
                              input logic eov, input logic [7:0] eod, input logic [2:0] esel,
                              input logic eir);
    vec_t v;
    v.iv = iv; v.isel = isel; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.esel = esel; v.eir = eir;
    tbl.push_back(v);
  endfunction

  // Reference for the random phase: a FIFO of expected beats, each tagged with
  // the count of advancing cycles seen at acceptance (must be exactly 3 at exit).
  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    int         t;
  } exp_t;
  exp_t exp_q[$];
  int   adv_cnt = 0;
  logic sb_en   = 1'b0;

  always @(negedge clk) begin
    if (sb_en) begin
      exp_t e;
      check("rand_in_ready", a_ir, !a_ov || a_ordy);
`ifdef MUX_TREE_SEL_ERR_EN
      check("rand_sel_err", a_err, 0);
`endif
      if (a_ov && a_ordy) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rand_data", a_od, e.d);
          check("rand_sel", a_osel, e.s);
          check("rand_latency", adv_cnt - e.t, 3);
        end
      end
      if (a_iv && a_ir) begin
        e.d = a_data[a_sel*8 +: 8];
        e.s = a_sel;
        e.t = adv_cnt;
        exp_q.push_back(e);
      end
      if (!a_ov || a_ordy) adv_cnt++;
    end
  end

  initial begin
    a_iv = 0; a_sel = 0; a_ordy = 1;
    b_iv = 0; b_sel = 0; b_ordy = 1;
    c_iv = 0; c_sel = 0; c_ordy = 1;
    for (int c = 0; c < 8; c++) a_data[c*8 +: 8] = 8'hA0 + 8'(c);
    for (int c = 0; c < 5; c++) b_data[c*8 +: 8] = 8'h50 + 8'(c);
    c_data = {16'hBEEF, 16'h1234};

    #1 rst = 1'b1;
    #1;
    check("rst_a_out_valid", a_ov, 0);
    check("rst_a_out_data", a_od, 0);
    check("rst_a_out_sel", a_osel, 0);
    check("rst_a_in_ready", a_ir, 1);
    check("rst_b_out_valid", b_ov, 0);
    check("rst_c_out_valid", c_ov, 0);
`ifdef MUX_TREE_SEL_ERR_EN
    check("rst_b_sel_err", b_err, 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_a_in_ready", a_ir, 1);

    // Back-to-back, 4-cycle stall on A5 (with ignored input), then a 1,0,1,0 bubble pattern.
    add(1, 0, 1, 0, 8'h00, 0, 1);
    add(1, 1, 1, 0, 8'h00, 0, 1);
    add(1, 2, 1, 0, 8'h00, 0, 1);
    add(1, 3, 1, 1, 8'hA0, 0, 1);
    add(1, 4, 1, 1, 8'hA1, 1, 1);
    add(1, 5, 1, 1, 8'hA2, 2, 1);
    add(1, 6, 1, 1, 8'hA3, 3, 1);
    add(1, 7, 1, 1, 8'hA4, 4, 1);
    add(1, 3, 0, 1, 8'hA5, 5, 0);
    add(1, 3, 0, 1, 8'hA5, 5, 0);
    add(1, 3, 0, 1, 8'hA5, 5, 0);
    add(1, 3, 0, 1, 8'hA5, 5, 0);
    add(0, 0, 1, 1, 8'hA5, 5, 1);
    add(0, 0, 1, 1, 8'hA6, 6, 1);
    add(0, 0, 1, 1, 8'hA7, 7, 1);
    add(1, 1, 1, 0, 8'h00, 0, 1);
    add(0, 0, 0, 0, 8'h00, 0, 1);
    add(1, 2, 0, 0, 8'h00, 0, 1);
    add(0, 0, 1, 1, 8'hA1, 1, 1);
    add(0, 0, 1, 0, 8'h00, 0, 1);
    add(0, 0, 1, 1, 8'hA2, 2, 1);
    add(0, 0, 1, 0, 8'h00, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      a_iv = tbl[i].iv; a_sel = tbl[i].isel; a_ordy = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("tbl%0d_out_valid", i), a_ov, tbl[i].eov);
      check($sformatf("tbl%0d_in_ready", i), a_ir, tbl[i].eir);
      if (tbl[i].eov) begin
        check($sformatf("tbl%0d_out_data", i), a_od, tbl[i].eod);
        check($sformatf("tbl%0d_out_sel", i), a_osel, tbl[i].esel);
      end
      @(posedge clk);
      #1;
    end

    // Reset with three beats in flight.
    for (int i = 0; i < 4; i++) begin
      a_iv = (i < 3); a_sel = 3'(i + 1); a_ordy = 1;
      @(negedge clk);
      if (i == 3) begin
        check("midrst_pre_valid", a_ov, 1);
        check("midrst_pre_data", a_od, 8'hA1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    a_iv = 0;
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", a_ov, 0);
    check("midrst_out_data", a_od, 0);
    check("midrst_out_sel", a_osel, 0);
    check("midrst_in_ready", a_ir, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("midrst_after%0d_valid", i), a_ov, 0);
      @(posedge clk);
      #1;
    end

    // 5-channel out-of-range select and 2-channel 16-bit tree.
    for (int k = 0; k < 6; k++) begin
      b_iv = (k < 2); b_sel = (k == 0) ? 3'd6 : 3'd4;
      c_iv = (k < 2); c_sel = (k == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      case (k)
        1: begin
          check("n2_beat0_valid", c_ov, 1);
          check("n2_beat0_data", c_od, 16'hBEEF);
          check("n2_beat0_sel", c_osel, 1);
        end
        2: begin
          check("n2_beat1_valid", c_ov, 1);
          check("n2_beat1_data", c_od, 16'h1234);
          check("n2_beat1_sel", c_osel, 0);
        end
        3: begin
          check("n2_idle_valid", c_ov, 0);
          check("n5_oor_valid", b_ov, 1);
          check("n5_oor_data", b_od, 0);
          check("n5_oor_sel", b_osel, 6);
`ifdef MUX_TREE_SEL_ERR_EN
          check("n5_oor_sel_err", b_err, 1);
`endif
        end
        4: begin
          check("n5_ch4_valid", b_ov, 1);
          check("n5_ch4_data", b_od, 8'h54);
          check("n5_ch4_sel", b_osel, 4);
`ifdef MUX_TREE_SEL_ERR_EN
          check("n5_ch4_sel_err", b_err, 0);
`endif
        end
        5: check("n5_idle_valid", b_ov, 0);
        default: check("n5_early_valid", b_ov, 0);
      endcase
      @(posedge clk);
      #1;
    end

    // Random traffic against the scoreboard, then drain.
    sb_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a_iv   = ($urandom_range(0, 3) != 0);
      a_sel  = 3'($urandom);
      a_data = {$urandom, $urandom};
      a_ordy = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    a_iv = 0; a_ordy = 1;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    sb_en = 1'b0;
    check("rand_drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
